// File: rtl/motor_drive_ctrl_pkg.sv
// Shared encodings for the motor drive controller: FSM states, direction and
// drive/stop levels (matching the collision stage), and the status LED decode.
package motor_drive_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP    = 3'd1,
        ST_RUN     = 3'd2,
        ST_REVERSE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef enum logic {
        BACKWARDS = 1'b0,
        FORWARDS  = 1'b1
    } dir_e;

    typedef enum logic {
        STOP  = 1'b0,
        DRIVE = 1'b1
    } drive_e;

    // One-hot status: [0] RUN/RAMP, [1] REVERSE, [2] HALT; IDLE shows nothing.
    function automatic logic [2:0] state_leds_of(input state_t s);
        case (s)
            ST_RAMP, ST_RUN: state_leds_of = 3'b001;
            ST_REVERSE:      state_leds_of = 3'b010;
            ST_HALT:         state_leds_of = 3'b100;
            default:         state_leds_of = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Free-running PWM counter with a registered compare against the applied duty.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + PWM_BITS'(1);
            pwm <= (cnt < duty);
        end
    end

endmodule

// File: rtl/motor_drive_ctrl.sv
// H-bridge drive controller: soft-start ramp, collision halt and dead-time on reversal.
// Soft-start ramping is built only when MOTOR_SOFT_START_EN is defined.
module motor_drive_ctrl
    import motor_drive_ctrl_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned RAMP_DIV = 50_000,
    parameter int unsigned DEADTIME = 5_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                colDetect,
    input  logic                direction,
    input  logic [PWM_BITS-1:0] speed,
    output logic                pwm_out,
    output logic                dir_out,
    output logic                brake,
    output logic [PWM_BITS-1:0] duty_now,
    output logic [2:0]          state_leds
);

    localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic                dir_nxt;
    logic                brake_nxt;
    logic [DEAD_W-1:0]   dead_cnt, dead_cnt_nxt;

`ifdef MOTOR_SOFT_START_EN
    localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

    logic [RAMP_W-1:0] ramp_cnt, ramp_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt_nxt;
        end
    end
`else
    // Ramp divider has no effect when duty is applied in a single step.
    logic [31:0] unused_ramp_div;
    assign unused_ramp_div = RAMP_DIV;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            duty_now   <= '0;
            dir_out    <= FORWARDS;
            brake      <= 1'b0;
            dead_cnt   <= '0;
            state_leds <= 3'b000;
        end else begin
            state      <= state_nxt;
            duty_now   <= duty_nxt;
            dir_out    <= dir_nxt;
            brake      <= brake_nxt;
            dead_cnt   <= dead_cnt_nxt;
            state_leds <= state_leds_of(state_nxt);
        end
    end

    // Next state: collision halt first, then reversal, then ramp/run.
    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty_now;
        dir_nxt      = dir_out;
        brake_nxt    = brake;
        dead_cnt_nxt = '0;
`ifdef MOTOR_SOFT_START_EN
        ramp_cnt_nxt = '0;
`endif
        if (colDetect == STOP) begin
            state_nxt = ST_HALT;
            duty_nxt  = '0;
            brake_nxt = 1'b1;
        end else begin
            case (state)
                ST_HALT: begin
                    brake_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
                ST_REVERSE: begin
                    if (direction == dir_out) begin
                        state_nxt = ST_RAMP;
                    end else if (dead_cnt == DEAD_LAST) begin
                        dir_nxt   = direction;
                        state_nxt = ST_RAMP;
                    end else begin
                        dead_cnt_nxt = dead_cnt + DEAD_W'(1);
                    end
                end
                ST_IDLE, ST_RAMP, ST_RUN: begin
                    if (direction != dir_out) begin
                        state_nxt = ST_REVERSE;
                        duty_nxt  = '0;
                    end else if (state == ST_IDLE) begin
                        if (speed != '0) begin
                            state_nxt = ST_RAMP;
                        end
                    end else if (state == ST_RAMP) begin
`ifdef MOTOR_SOFT_START_EN
                        if (duty_now == speed) begin
                            state_nxt = ST_RUN;
                        end else if (ramp_cnt == RAMP_LAST) begin
                            if (duty_now < speed) begin
                                duty_nxt = (duty_now == DUTY_MAX) ? duty_now : duty_now + PWM_BITS'(1);
                            end else begin
                                duty_nxt = (duty_now == '0) ? duty_now : duty_now - PWM_BITS'(1);
                            end
                        end else begin
                            ramp_cnt_nxt = ramp_cnt + RAMP_W'(1);
                        end
`else
                        duty_nxt  = speed;
                        state_nxt = ST_RUN;
`endif
                    end else begin
                        if (speed != duty_now) begin
                            state_nxt = ST_RAMP;
                        end else if (speed == '0) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    duty_nxt  = '0;
                    brake_nxt = 1'b0;
                end
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_gen (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_now),
        .pwm  (pwm_out)
    );

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: directed scenarios with literal expectations, then
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_motor_drive_ctrl;

    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned RAMP_DIV = 4;
    localparam int unsigned DEADTIME = 8;
    localparam int PERIOD = 1 << PWM_BITS;
`ifdef MOTOR_SOFT_START_EN
    localparam int TGT = 6;
`else
    localparam int TGT = 15;
`endif

    logic                clk;
    logic                rst;
    logic                colDetect;
    logic                direction;
    logic [PWM_BITS-1:0] speed;
    logic                pwm_out;
    logic                dir_out;
    logic                brake;
    logic [PWM_BITS-1:0] duty_now;
    logic [2:0]          state_leds;

    int n_checks = 0;
    int n_err    = 0;

    motor_drive_ctrl #(
        .PWM_BITS(PWM_BITS),
        .RAMP_DIV(RAMP_DIV),
        .DEADTIME(DEADTIME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .colDetect  (colDetect),
        .direction  (direction),
        .speed      (speed),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .brake      (brake),
        .duty_now   (duty_now),
        .state_leds (state_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: operating mode plus remaining dead time and ramp ticks.
    localparam int M_IDLE = 0, M_RAMPING = 1, M_HOLD = 2, M_REVERSING = 3, M_HALTED = 4;
    int m_cnt, m_duty, m_mode, m_tick, m_dead_left;
    bit m_pwm, m_dir, m_brake;

    function automatic int leds_for(input int mode);
        if (mode == M_RAMPING || mode == M_HOLD) return 1;
        if (mode == M_REVERSING) return 2;
        if (mode == M_HALTED) return 4;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_pwm = 0; m_duty = 0; m_dir = 1; m_brake = 0;
            m_mode = M_IDLE; m_tick = 0; m_dead_left = 0;
        end else begin
            m_pwm = (m_cnt < m_duty);
            m_cnt = (m_cnt + 1) % PERIOD;
            if (!colDetect) begin
                m_mode = M_HALTED; m_duty = 0; m_brake = 1;
            end else if (m_mode == M_HALTED) begin
                m_brake = 0; m_mode = M_IDLE;
            end else if (m_mode == M_REVERSING) begin
                m_dead_left = m_dead_left - 1;
                if (direction == m_dir) begin
                    m_mode = M_RAMPING; m_tick = 0;
                end else if (m_dead_left == 0) begin
                    m_dir = direction; m_mode = M_RAMPING; m_tick = 0;
                end
            end else if (direction != m_dir) begin
                m_mode = M_REVERSING; m_duty = 0; m_dead_left = DEADTIME;
            end else if (m_mode == M_IDLE) begin
                if (speed != 0) begin m_mode = M_RAMPING; m_tick = 0; end
            end else if (m_mode == M_RAMPING) begin
`ifdef MOTOR_SOFT_START_EN
                if (m_duty == int'(speed)) begin
                    m_mode = M_HOLD;
                end else begin
                    m_tick = m_tick + 1;
                    if (m_tick == RAMP_DIV) begin
                        m_tick = 0;
                        m_duty = (m_duty < int'(speed)) ? m_duty + 1 : m_duty - 1;
                        if (m_duty < 0) m_duty = 0;
                        if (m_duty > PERIOD - 1) m_duty = PERIOD - 1;
                    end
                end
`else
                m_duty = int'(speed); m_mode = M_HOLD;
`endif
            end else begin
                if (int'(speed) != m_duty) begin
                    m_mode = M_RAMPING; m_tick = 0;
                end else if (speed == 0) begin
                    m_mode = M_IDLE;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock, then compare every output against the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            n_checks++;
            if (pwm_out !== m_pwm || dir_out !== m_dir || brake !== m_brake ||
                int'(duty_now) != m_duty || int'(state_leds) != leds_for(m_mode)) begin
                n_err++;
                $display("FAIL model_cmp t=%0t: got pwm=%0b dir=%0b brake=%0b duty=%0d leds=%03b expected pwm=%0b dir=%0b brake=%0b duty=%0d leds=%03b",
                         $time, pwm_out, dir_out, brake, duty_now, state_leds,
                         m_pwm, m_dir, m_brake, m_duty, 3'(leds_for(m_mode)));
            end
        end
    endtask

    task automatic wait_run(input string name);
        bit found = 0;
        for (int i = 0; i < 120 && !found; i++) begin
            tick();
            if (state_leds == 3'b001 && int'(duty_now) == TGT && int'(speed) == TGT) found = 1;
        end
        check(name, int'(found), 1);
        tick();
        tick();
    endtask

    initial begin
        int  cnt;
        int  highs;
        bit  held;
        rst = 1'b0; colDetect = 1'b1; direction = 1'b1; speed = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_dir", int'(dir_out), 1);
        check("rst_brake", int'(brake), 0);
        check("rst_duty", int'(duty_now), 0);
        check("rst_leds", int'(state_leds), 0);

        rst = 1'b1; speed = PWM_BITS'(TGT);
        cnt = 0;
        while (int'(duty_now) != TGT && cnt < 40) begin
            tick();
            cnt++;
        end
`ifdef MOTOR_SOFT_START_EN
        check("ramp_time_ok", int'(cnt >= 23 && cnt <= 25), 1);
`else
        check("step_time_ok", int'(cnt <= 2), 1);
`endif
        tick(); tick();
        check("run_leds", int'(state_leds), 1);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            highs += int'(pwm_out);
        end
        check("pwm_high_count", highs, TGT);

        // Collision stop and recovery
        colDetect = 1'b0;
        tick();
        check("halt_brake", int'(brake), 1);
        check("halt_duty", int'(duty_now), 0);
        check("halt_leds", int'(state_leds), 4);
        tick();
        check("halt_pwm", int'(pwm_out), 0);
        colDetect = 1'b1;
        tick();
        check("unhalt_brake", int'(brake), 0);
        check("unhalt_leds", int'(state_leds), 0);
        tick();
        check("restart_leds", int'(state_leds), 1);
        check("restart_duty", int'(duty_now), 0);
        wait_run("run_after_halt");

        // Reversal with full dead time
        direction = 1'b0;
        tick();
        check("rev_duty", int'(duty_now), 0);
        check("rev_leds", int'(state_leds), 2);
        check("rev_dir_entry", int'(dir_out), 1);
        held = 1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (dir_out !== 1'b1) held = 0;
        end
        check("rev_dir_held", int'(held), 1);
        tick();
        check("rev_dir_toggled", int'(dir_out), 0);
        check("rev_ramp_leds", int'(state_leds), 1);
        wait_run("run_after_rev");

        // Direction glitch shorter than dead time
        held = 1;
        direction = 1'b1;
        tick(); if (dir_out !== 1'b0) held = 0;
        tick(); if (dir_out !== 1'b0) held = 0;
        direction = 1'b0;
        tick();
        check("glitch_duty", int'(duty_now), 0);
        check("glitch_leds", int'(state_leds), 1);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (dir_out !== 1'b0) held = 0;
        end
        check("glitch_dir_held", int'(held), 1);
        wait_run("run_after_glitch");

        // Collision coinciding with a direction change
        colDetect = 1'b0; direction = 1'b1;
        tick();
        check("coinc_leds", int'(state_leds), 4);
        check("coinc_brake", int'(brake), 1);
        check("coinc_dir", int'(dir_out), 0);
        tick();
        check("coinc_pwm", int'(pwm_out), 0);
        colDetect = 1'b1;
        wait_run("run_after_coinc");

        // Reset in the middle of a PWM period
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_duty", int'(duty_now), 0);
        check("arst_dir", int'(dir_out), 1);
        check("arst_leds", int'(state_leds), 0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized operation
        for (int i = 0; i < 4000; i++) begin
            tick();
            colDetect = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 2) direction = ~direction;
            if ($urandom_range(0, 99) < 3) speed = PWM_BITS'($urandom_range(0, PERIOD - 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
